// File: rtl/azadi_prog_pkg.sv
// Shared types and constants for the boot-programming loader.
package azadi_prog_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_LEN,
      ST_LOAD,
      ST_DONE,
      ST_ERR
   } prog_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   localparam logic [15:0] MIN_CPB   = 16'd4;
   localparam int unsigned LEN_BYTES = 4;

endpackage

// File: rtl/azadi_uart_rx_core.sv
// 8N1 UART receiver: start re-sampled at mid-bit, data LSB first, then stop bit.
// byte_valid_o / frame_err_o are single-cycle strobes in the stop-sample cycle.
module azadi_uart_rx_core
   import azadi_prog_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        rx_i,
   input  logic [15:0] cpb_i,
   output logic        byte_valid_o,
   output logic [7:0]  byte_data_o,
   output logic        frame_err_o
);

   rx_state_e   st_q, st_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_prev_q;
   logic [15:0] half_m1, full_m1;

   assign half_m1     = (cpb_i >> 1) - 16'd1;
   assign full_m1     = cpb_i - 16'd1;
   assign byte_data_o = shift_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q      <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_prev_q <= 1'b1;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_prev_q <= rx_i;
      end
   end

   always_comb begin
      st_d         = st_q;
      cnt_d        = cnt_q + 16'd1;
      bit_d        = bit_q;
      shift_d      = shift_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      if (clr_i) begin
         st_d  = RX_IDLE;
         cnt_d = '0;
         bit_d = '0;
      end else begin
         case (st_q)
            RX_IDLE: begin
               cnt_d = '0;
               if (rx_prev_q && !rx_i) st_d = RX_START;
            end
            RX_START: begin
               // A start bit that reads high at mid-bit was only a glitch.
               if (cnt_q == half_m1) begin
                  cnt_d = '0;
                  bit_d = '0;
                  st_d  = rx_i ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (cnt_q == full_m1) begin
                  cnt_d   = '0;
                  shift_d = {rx_i, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) st_d = RX_STOP;
               end
            end
            RX_STOP: begin
               if (cnt_q == full_m1) begin
                  cnt_d        = '0;
                  st_d         = RX_IDLE;
                  byte_valid_o = rx_i;
                  frame_err_o  = !rx_i;
               end
            end
            default: st_d = RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/azadi_prog_loader.sv
// Boot loader: holds the core in reset while prog is high and writes a UART image into IMEM.
// Define PROG_CHECKSUM_EN to require a trailing 32-bit additive checksum word.
module azadi_prog_loader
   import azadi_prog_pkg::*;
#(
   parameter int ADDR_W          = 12,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              prog_i,
   input  logic              rx_i,
   input  logic [15:0]       clks_per_bit_i,
   output logic              core_rst_no,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [31:0]       wdata_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [32:0]     MAX_LEN = 33'd1 << ADDR_W;

   logic [1:0]      prog_sync_q, rx_sync_q;
   logic            prog_s, rx_s;
   logic            db_q, prog_rise_q, prog_fall_q;
   logic [DB_W-1:0] db_cnt_q;

   prog_state_e     state_q, state_d;
   logic [15:0]     cpb_q, cpb_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [31:0]     word_q, word_d, word_full;
   logic [ADDR_W-1:0] last_q, last_d, ptr_q, ptr_d, addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            we_q, we_d;
   logic            core_rst_q, busy_q, err_q;
   logic            restart, loading, word_done, rx_clr;
   logic            byte_valid, frame_err;
   logic [7:0]      byte_data;
`ifdef PROG_CHECKSUM_EN
   logic [31:0]     sum_q, sum_d;
   logic            chk_q, chk_d;
`endif

   assign prog_s = prog_sync_q[1];
   assign rx_s   = rx_sync_q[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prog_sync_q <= 2'b00;
         rx_sync_q   <= 2'b11;
      end else begin
         prog_sync_q <= {prog_sync_q[0], prog_i};
         rx_sync_q   <= {rx_sync_q[0], rx_i};
      end
   end

   // Accept a level change only after it has held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         db_q        <= 1'b0;
         db_cnt_q    <= '0;
         prog_rise_q <= 1'b0;
         prog_fall_q <= 1'b0;
      end else begin
         prog_rise_q <= 1'b0;
         prog_fall_q <= 1'b0;
         if (prog_s == db_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_LAST) begin
            db_q        <= prog_s;
            db_cnt_q    <= '0;
            prog_rise_q <= prog_s;
            prog_fall_q <= !prog_s;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end
   end

   assign restart   = prog_rise_q && (state_q != ST_ERR);
   assign loading   = (state_q == ST_WAIT_LEN) || (state_q == ST_LOAD);
   assign rx_clr    = !loading || restart;
   assign word_full = {byte_data, word_q[31:8]};
   assign word_done = byte_valid && (byte_cnt_q == 2'(LEN_BYTES - 1));

   azadi_uart_rx_core u_rx (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_i        (rx_clr),
      .rx_i         (rx_s),
      .cpb_i        (cpb_q),
      .byte_valid_o (byte_valid),
      .byte_data_o  (byte_data),
      .frame_err_o  (frame_err)
   );

   always_comb begin
      state_d    = state_q;
      cpb_d      = cpb_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      last_d     = last_q;
      ptr_d      = ptr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_d      = sum_q;
      chk_d      = chk_q;
`endif
      if (restart) begin
         cpb_d      = clks_per_bit_i;
         byte_cnt_d = '0;
         word_d     = '0;
         ptr_d      = '0;
`ifdef PROG_CHECKSUM_EN
         sum_d      = '0;
         chk_d      = 1'b0;
`endif
         state_d    = (clks_per_bit_i < MIN_CPB) ? ST_ERR : ST_WAIT_LEN;
      end else if (prog_fall_q && (loading || state_q == ST_ERR)) begin
         state_d = ST_IDLE;
      end else if (loading && frame_err) begin
         state_d = ST_ERR;
      end else if (loading) begin
         if (byte_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_d     = word_full;
         end
         if (state_q == ST_WAIT_LEN) begin
            if (word_done) begin
               if ((word_full != 32'd0) && ({1'b0, word_full} <= MAX_LEN)) begin
                  last_d  = ADDR_W'(word_full - 32'd1);
                  ptr_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end else begin
            // Address advances the cycle after the strobe; it never passes last_q.
            if (we_q) begin
               if (ptr_q == last_q) begin
`ifdef PROG_CHECKSUM_EN
                  chk_d = 1'b1;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
            if (word_done) begin
`ifdef PROG_CHECKSUM_EN
               if (chk_q) begin
                  state_d = (word_full == sum_q) ? ST_DONE : ST_ERR;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = ptr_q;
                  wdata_d = word_full;
                  sum_d   = sum_q + word_full;
               end
`else
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = word_full;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cpb_q      <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         last_q     <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         core_rst_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
         sum_q      <= '0;
         chk_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cpb_q      <= cpb_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         last_q     <= last_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         core_rst_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
         busy_q     <= (state_d == ST_WAIT_LEN) || (state_d == ST_LOAD);
         err_q      <= (state_d == ST_ERR);
`ifdef PROG_CHECKSUM_EN
         sum_q      <= sum_d;
         chk_q      <= chk_d;
`endif
      end
   end

   assign core_rst_no = core_rst_q;
   assign we_o        = we_q;
   assign addr_o      = addr_q;
   assign wdata_o     = wdata_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_azadi_prog_loader.sv
// Directed bench for azadi_prog_loader; checksum cases run when PROG_CHECKSUM_EN is defined.
module tb_azadi_prog_loader;

   localparam int DB  = 8;
   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog;
   logic        rx;
   logic [15:0] cpb;
   logic        core_rst_no, we_o, busy_o, err_o;
   logic [11:0] addr_o;
   logic [31:0] wdata_o;

   int n_checks = 0;
   int n_fail   = 0;
   int base;

   logic [11:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [31:0] exp_t1[3] = '{32'h0000_0013, 32'hDEAD_BEEF, 32'h1234_5678};

   azadi_prog_loader #(.ADDR_W(12), .DEBOUNCE_CYCLES(DB)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .prog_i         (prog),
      .rx_i           (rx),
      .clks_per_bit_i (cpb),
      .core_rst_no    (core_rst_no),
      .we_o           (we_o),
      .addr_o         (addr_o),
      .wdata_o        (wdata_o),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we_o) begin
         wr_addr.push_back(addr_o);
         wr_data.push_back(wdata_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_bit;
      tick(CPB);
      rx = 1'b1;
      tick(4);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic prog_set(input logic v);
      prog = v;
      tick(DB + 8);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      prog  = 1'b0;
      rx    = 1'b1;
      cpb   = 16'd16;
      tick(3);
      check("rst_core_rst_no", core_rst_no, 0);
      check("rst_we", we_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_wdata", wdata_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      rst_n = 1'b1;
      tick(1);
      check("idle_core_rst_no", core_rst_no, 1);

      // Nominal three-word image
      base = wr_addr.size();
      prog_set(1'b1);
      check("t1_busy", busy_o, 1);
      check("t1_core_held", core_rst_no, 0);
      send_word(32'd3);
      for (int i = 0; i < 3; i++) send_word(exp_t1[i]);
`ifdef PROG_CHECKSUM_EN
      send_word(32'hF0E2_157A);
`endif
      tick(4);
      check("t1_wr_count", wr_addr.size() - base, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t1_addr%0d", i), wr_addr[base+i], i);
         check($sformatf("t1_data%0d", i), wr_data[base+i], exp_t1[i]);
      end
      check("t1_done_core_rst_no", core_rst_no, 1);
      check("t1_done_busy", busy_o, 0);
      check("t1_done_err", err_o, 0);
      prog_set(1'b0);
      check("t1_done_after_fall", core_rst_no, 1);

      // Length 0 rejected
      prog_set(1'b1);
      send_word(32'd0);
      tick(4);
      check("len0_err", err_o, 1);
      check("len0_core_held", core_rst_no, 0);
      check("len0_busy", busy_o, 0);
      prog_set(1'b0);
      check("len0_idle_err", err_o, 0);
      check("len0_idle_core", core_rst_no, 1);

      // Length 4097 rejected, 4096 accepted
      prog_set(1'b1);
      send_word(32'd4097);
      tick(4);
      check("len4097_err", err_o, 1);
      check("len4097_core_held", core_rst_no, 0);
      prog_set(1'b0);
      prog_set(1'b1);
      send_word(32'd4096);
      tick(4);
      check("len4096_busy", busy_o, 1);
      check("len4096_err", err_o, 0);
      prog_set(1'b0);
      check("len4096_abort_busy", busy_o, 0);

      // Baud divisor below minimum
      cpb = 16'd3;
      prog_set(1'b1);
      check("cpb3_err", err_o, 1);
      check("cpb3_core_held", core_rst_no, 0);
      prog_set(1'b0);
      cpb = 16'd16;
      check("cpb3_idle_err", err_o, 0);

      // Framing error on second byte of word 1
      base = wr_addr.size();
      prog_set(1'b1);
      send_word(32'd2);
      send_word(32'hA5A5_0001);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      tick(4);
      check("ferr_err", err_o, 1);
      check("ferr_wr_count", wr_addr.size() - base, 1);
      check("ferr_addr0", wr_addr[base], 0);
      check("ferr_data0", wr_data[base], 32'hA5A5_0001);
      prog_set(1'b0);

      // Abort after 2 of 5 words
      base = wr_addr.size();
      prog_set(1'b1);
      send_word(32'd5);
      send_word(32'h0000_1111);
      send_word(32'h0000_2222);
      prog_set(1'b0);
      check("abort_core_rst_no", core_rst_no, 1);
      check("abort_busy", busy_o, 0);
      send_word(32'h0000_3333);
      tick(4);
      check("abort_wr_count", wr_addr.size() - base, 2);
      check("abort_addr1", wr_addr[base+1], 1);

`ifdef PROG_CHECKSUM_EN
      base = wr_addr.size();
      prog_set(1'b1);
      send_word(32'd2);
      send_word(32'd1);
      send_word(32'd2);
      send_word(32'd3);
      tick(4);
      check("csum_ok_core_rst_no", core_rst_no, 1);
      check("csum_ok_err", err_o, 0);
      check("csum_ok_busy", busy_o, 0);
      check("csum_ok_wr_count", wr_addr.size() - base, 2);
      prog_set(1'b0);
      base = wr_addr.size();
      prog_set(1'b1);
      send_word(32'd2);
      send_word(32'd1);
      send_word(32'd2);
      send_word(32'd4);
      tick(4);
      check("csum_bad_err", err_o, 1);
      check("csum_bad_wr_count", wr_addr.size() - base, 2);
      prog_set(1'b0);
`endif

      // Asynchronous reset mid-word
      prog_set(1'b1);
      send_word(32'd5);
      send_word(32'hCAFE_F00D);
      send_byte(8'h77, 1'b1);
      tick(3);
      check("pre_rst_wdata", wdata_o, 32'hCAFE_F00D);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_core_rst_no", core_rst_no, 0);
      check("async_rst_we", we_o, 0);
      check("async_rst_addr", addr_o, 0);
      check("async_rst_wdata", wdata_o, 0);
      check("async_rst_busy", busy_o, 0);
      check("async_rst_err", err_o, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
